// File: rtl/reg_bank_pkg.sv
// reg_bank shared types: access FSM states and read/write encodings.
// Build option: define REG_BANK_LOCK_EN to add the write-lock register.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK,
    WAIT
  } state_t;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/reg_bank_ctrl.sv
// reg_bank access FSM, request capture and address decode.
// Build option: REG_BANK_LOCK_EN adds lock-address decode and write blocking.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int W_WIDTH   = 8,
  parameter int NUM_REGS  = 4,
  parameter int IW        = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_en,
  input  logic               wr_rd_s,
  input  logic [W_WIDTH-1:0] addr,
  input  logic [W_WIDTH-1:0] wr_data,
`ifdef REG_BANK_LOCK_EN
  input  logic               lock,
  output logic               lock_we,
  output logic               rd_lock,
`endif
  output logic               ack,
  output logic               err,
  output logic               we,
  output logic               rd_en,
  output logic [IW-1:0]      idx,
  output logic [W_WIDTH-1:0] wdata
);

`ifdef REG_BANK_LOCK_EN
  localparam int LOCK_N = 1;
`else
  localparam int LOCK_N = 0;
`endif

  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num
    $error("reg_bank: NUM_REGS must be 1..16");
  end
  if ((64'(BASE_ADDR) + 64'(NUM_REGS) + 64'(LOCK_N))
      > (64'd1 << W_WIDTH)) begin : g_bad_map
    $error("reg_bank: register map exceeds address space");
  end

  localparam logic [W_WIDTH-1:0] BASE = W_WIDTH'(BASE_ADDR);
  localparam logic [W_WIDTH:0]   NREG = (W_WIDTH+1)'(NUM_REGS);

  state_t state, nxt;

  logic [W_WIDTH-1:0] a_q;
  logic [W_WIDTH-1:0] d_q;
  logic               wr_q;
  logic [W_WIDTH:0]   off;
  logic               hit;
  logic               lk_hit;
  logic               blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (sel_en) nxt = ACCESS;
      ACCESS:  nxt = ACK;
      ACK:     nxt = sel_en ? WAIT : IDLE;
      WAIT:    if (!sel_en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      d_q  <= '0;
      wr_q <= OP_RD;
    end else if (state == IDLE && sel_en) begin
      a_q  <= addr;
      d_q  <= wr_data;
      wr_q <= wr_rd_s;
    end
  end

  // widened subtract so addresses below BASE wrap out of range
  assign off = {1'b0, a_q} - {1'b0, BASE};
  assign hit = (a_q >= BASE) && (off < NREG);
  assign idx = off[IW-1:0];
  assign wdata = d_q;

`ifdef REG_BANK_LOCK_EN
  assign lk_hit  = (a_q >= BASE) && (off == NREG);
  assign blocked = lock;
  assign lock_we = (state == ACCESS) && (wr_q == OP_WR)
                   && lk_hit && d_q[0];
  assign rd_lock = ack && (wr_q == OP_RD) && lk_hit;
`else
  assign lk_hit  = 1'b0;
  assign blocked = 1'b0;
`endif

  assign ack   = (state == ACK);
  assign we    = (state == ACCESS) && (wr_q == OP_WR)
                 && hit && !blocked;
  assign rd_en = ack && (wr_q == OP_RD) && hit;
  assign err   = ack && (!(hit || lk_hit)
                 || ((wr_q == OP_WR) && hit && blocked));

endmodule

// File: rtl/reg_bank.sv
// reg_bank top: configuration register array, lock bit and read mux.
// Build option: REG_BANK_LOCK_EN adds a sticky lock at BASE_ADDR+NUM_REGS.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                  BASE_ADDR = 0,
  parameter int                  W_WIDTH   = 8,
  parameter int                  NUM_REGS  = 4,
  parameter logic [W_WIDTH-1:0]  RST_VAL   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sel_en,
  input  logic                        wr_rd_s,
  input  logic [W_WIDTH-1:0]          addr,
  input  logic [W_WIDTH-1:0]          wr_data,
  output logic [W_WIDTH-1:0]          rd_data,
  output logic                        ack,
  output logic                        err,
  output logic [NUM_REGS*W_WIDTH-1:0] reg_data2port_out
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [W_WIDTH-1:0] regs [NUM_REGS];
  logic               we;
  logic               rd_en;
  logic [IW-1:0]      idx;
  logic [W_WIDTH-1:0] wdata;

`ifdef REG_BANK_LOCK_EN
  logic lock;
  logic lock_we;
  logic rd_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lock <= 1'b0;
    else if (lock_we) lock <= 1'b1;
  end
`endif

  reg_bank_ctrl #(
    .BASE_ADDR (BASE_ADDR),
    .W_WIDTH   (W_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IW        (IW)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_en  (sel_en),
    .wr_rd_s (wr_rd_s),
    .addr    (addr),
    .wr_data (wr_data),
`ifdef REG_BANK_LOCK_EN
    .lock    (lock),
    .lock_we (lock_we),
    .rd_lock (rd_lock),
`endif
    .ack     (ack),
    .err     (err),
    .we      (we),
    .rd_en   (rd_en),
    .idx     (idx),
    .wdata   (wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (we) begin
      regs[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_data2port_out[g*W_WIDTH +: W_WIDTH] = regs[g];
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_en:   rd_data = regs[idx];
`ifdef REG_BANK_LOCK_EN
      rd_lock: rd_data = W_WIDTH'(lock);
`endif
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed scoreboard bench for reg_bank (default parameters).
// Lock checks compile in when REG_BANK_LOCK_EN is defined.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_en = 1'b0;
  logic        wr_rd_s = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        ack;
  logic        err;
  logic [31:0] port_out;

`ifdef REG_BANK_LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mreg [4];
  bit         mlock;
  logic [8:0] sb [$];

  reg_bank #(
    .BASE_ADDR (0),
    .W_WIDTH   (8),
    .NUM_REGS  (4),
    .RST_VAL   (8'h00)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sel_en            (sel_en),
    .wr_rd_s           (wr_rd_s),
    .addr              (addr),
    .wr_data           (wr_data),
    .rd_data           (rd_data),
    .ack               (ack),
    .err               (err),
    .reg_data2port_out (port_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_port();
    return {mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mlock = 1'b0;
  endtask

  // mode 0: drop sel in ACK, 1: hold into WAIT,
  // 2: drop sel in ACCESS, 3: reset during ACCESS
  task automatic access(input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int mode);
    bit hit, lk, e;
    logic [7:0] r;
    logic [8:0] exp;
    hit = (a < 8'd4);
    lk  = HAS_LOCK && (a == 8'd4);
    e   = !(hit || lk) || (wr && hit && mlock);
    r   = 8'h00;
    if (!wr && hit) r = mreg[a[1:0]];
    if (!wr && lk)  r = {7'b0, mlock};
    if (mode != 3) begin
      if (wr && hit && !mlock) mreg[a[1:0]] = d;
      if (wr && lk && d[0])    mlock = 1'b1;
      sb.push_back({e, r});
    end
    @(negedge clk);
    sel_en = 1'b1; wr_rd_s = wr; addr = a; wr_data = d;
    @(posedge clk); #1;
    chk("ack_in_access", {31'b0, ack}, 32'd0);
    if (mode == 2) sel_en = 1'b0;
    if (mode == 3) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("ack_in_reset", {31'b0, ack}, 32'd0);
      chk("rd_in_reset", {24'b0, rd_data}, 32'd0);
      sel_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("no_ack_after_rst", {31'b0, ack}, 32'd0);
      end
      chk("port_after_rst", port_out, model_port());
      return;
    end
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, ack}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      chk("err", {31'b0, err}, {31'b0, exp[8]});
      chk("rd_data", {24'b0, rd_data}, {24'b0, exp[7:0]});
    end
    chk("port_in_ack", port_out, model_port());
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk("wait_no_ack", {31'b0, ack}, 32'd0);
      end
    end
    sel_en = 1'b0;
    @(posedge clk); #1;
    chk("ack_after", {31'b0, ack}, 32'd0);
    chk("err_after", {31'b0, err}, 32'd0);
    chk("rd_after", {24'b0, rd_data}, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_port", port_out, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd", {24'b0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 8'd2, 8'hA5, 0);
    chk("reg2_bits", {24'b0, port_out[23:16]}, 32'hA5);
    access(1'b0, 8'd2, 8'h00, 1);
    access(1'b1, 8'd9, 8'h3C, 0);
    access(1'b1, 8'd0, 8'h11, 2);
    access(1'b0, 8'd0, 8'h00, 0);
    access(1'b1, 8'd3, 8'h5A, 0);
    access(1'b0, 8'd3, 8'h00, 0);
    access(1'b0, 8'd1, 8'h00, 0);
    access(1'b0, 8'hFF, 8'h00, 0);
    access(1'b1, 8'd1, 8'hFF, 3);
    access(1'b0, 8'd1, 8'h00, 0);
    access(1'b1, 8'd2, 8'hC3, 0);
    access(1'b0, 8'd4, 8'h00, 0);
`ifdef REG_BANK_LOCK_EN
    access(1'b1, 8'd4, 8'h01, 0);
    access(1'b1, 8'd0, 8'h77, 0);
    access(1'b0, 8'd0, 8'h00, 0);
    access(1'b0, 8'd4, 8'h00, 0);
`else
    access(1'b1, 8'd4, 8'h01, 0);
    access(1'b1, 8'd0, 8'h77, 0);
    access(1'b0, 8'd0, 8'h00, 0);
`endif
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0: address of register 0.
REQ-002 SHALL have parameter W_WIDTH, default 8: width of address, data and each register.
REQ-003 SHALL have parameter NUM_REGS, default 4, range 1..16: number of configuration registers.
REQ-004 SHALL have parameter RST_VAL, default 0: reset value of every configuration register.
REQ-005 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port sel_en  input  1: access request, held high until ack seen.
REQ-008 SHALL have port wr_rd_s  input  1: 1 = write, 0 = read.
REQ-009 SHALL have port addr  input  W_WIDTH: access address.
REQ-010 SHALL have port wr_data  input  W_WIDTH: write data.
REQ-011 SHALL have port rd_data  output  W_WIDTH: read data, valid only while ack is high.
REQ-012 SHALL have port ack  output  1: one-cycle completion pulse.
REQ-013 SHALL have port err  output  1: error flag, valid only while ack is high.
REQ-014 SHALL have port reg_data2port_out  output  NUM_REGS*W_WIDTH: all register contents, register i at bits [i*W_WIDTH +: W_WIDTH].

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, ACK, WAIT.
REQ-016 IDLE: sel_en high at edge -> ACCESS; addr, wr_data, wr_rd_s captured at that same edge.
REQ-017 ACCESS -> ACK unconditionally; sel_en dropping in ACCESS SHALL NOT abort the transaction.
REQ-018 ACK: ack = 1 for exactly one cycle; sel_en high -> WAIT, else -> IDLE.
REQ-019 WAIT: sel_en low -> IDLE; new request only accepted from IDLE (no back-to-back without a low cycle).
REQ-020 Hit when BASE_ADDR <= captured addr <= BASE_ADDR+NUM_REGS-1; index = addr - BASE_ADDR.
REQ-021 Write hit: register[index] updated at ACCESS->ACK edge; visible on reg_data2port_out in the ACK cycle.
REQ-022 Read hit: rd_data = register[index] during ACK; rd_data = 0 in all other cycles.
REQ-023 Miss: no register modified; rd_data = 0; err = 1 during ACK.
REQ-024 err SHALL be 0 whenever ack is 0.
REQ-025 Parameters with BASE_ADDR+NUM_REGS > 2**W_WIDTH SHALL be rejected at elaboration.

Reset
REQ-026 rst_n low SHALL immediately force FSM to IDLE, ack = 0, err = 0, rd_data = 0, every register = RST_VAL.
REQ-027 Reset mid-transaction SHALL abandon it: no write commits, no ack issued after release.

Configuration
REQ-028 Macro REG_BANK_LOCK_EN SHALL compile in a lock register at address BASE_ADDR+NUM_REGS (range check extends by one).
REQ-029 With REG_BANK_LOCK_EN: writing bit0 = 1 sets lock; lock clears only on reset; reading returns lock in bit0, zeros above.
REQ-030 With REG_BANK_LOCK_EN and lock set: writes to data registers SHALL not update and SHALL return err = 1; reads unaffected.
REQ-031 Without REG_BANK_LOCK_EN: address BASE_ADDR+NUM_REGS is a miss; no lock logic exists.

Structure
REQ-032 Package reg_bank_pkg SHALL hold the FSM state enum and the write/read encoding constants.
REQ-033 FSM plus address decode SHALL live in sub-module reg_bank_ctrl; the register array stays in reg_bank.

Verification
REQ-034 Reset: rst_n low -> all 4 registers 0x00, ack 0, rd_data 0x00.
REQ-035 Write 0xA5 to addr 2, then read addr 2 -> ack 2 cycles after sel_en sampled, rd_data 0xA5, err 0, bits [23:16] of port out = 0xA5.
REQ-036 Write 0x3C to addr 9 (NUM_REGS 4, BASE 0) -> ack with err 1, all registers unchanged.
REQ-037 sel_en dropped in ACCESS cycle during write 0x11 to addr 0 -> ack still pulses, register 0 = 0x11, FSM returns to IDLE.
REQ-038 rst_n asserted in ACCESS of write 0xFF to addr 1 -> register 1 stays 0x00, no ack after release.
REQ-039 REG_BANK_LOCK_EN: write 0x01 to addr 4, then write 0x77 to addr 0 -> err 1, register 0 unchanged; read addr 4 -> 0x01.
